// File: rtl/ov7670_config_seq.sv
// ov7670_config_seq: walks the ov7670_init {addr,value} table and issues one SCCB
// write per entry. Spaces writes with an idle gap, and uses a long settle after a
// COM7 soft reset. Aborts on an accept timeout or a NACK.
// Optional build macro OV7670_CFG_RETRY_EN: a NACKed register is retried up to
// MAX_RETRIES times before the sequence aborts.
module ov7670_config_seq #(
  parameter logic [15:0] WRITE_GAP      = 16'd100,
  parameter logic [19:0] RESET_DELAY    = 20'd50000,
  parameter logic [7:0]  ACCEPT_TIMEOUT = 8'd16,
  parameter logic [1:0]  MAX_RETRIES    = 2'd3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] init_data,
  input  logic        init_done,
  output logic        init_continue,
  output logic        init_reset_n,
  output logic [7:0]  sccb_addr,
  output logic [7:0]  sccb_value,
  output logic        sccb_start,
  input  logic        sccb_busy,
  input  logic        sccb_nack,
  output logic        busy,
  output logic        cfg_done,
  output logic        cfg_error,
  output logic [7:0]  reg_count
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_REWIND  = 4'd1;
  localparam logic [3:0] S_FETCH   = 4'd2;
  localparam logic [3:0] S_ISSUE   = 4'd3;
  localparam logic [3:0] S_WACCEPT = 4'd4;
  localparam logic [3:0] S_WXFER   = 4'd5;
  localparam logic [3:0] S_CHECK   = 4'd6;
  localparam logic [3:0] S_GAP     = 4'd7;
  localparam logic [3:0] S_ADVANCE = 4'd8;
  localparam logic [3:0] S_DONE    = 4'd9;
  localparam logic [3:0] S_ERROR   = 4'd10;

`ifdef OV7670_CFG_RETRY_EN
  localparam logic RETRY_EN = 1'b1;
`else
  localparam logic RETRY_EN = 1'b0;
`endif
  // A zero limit turns the first NACK into an abort.
  localparam logic [1:0]  RETRY_LIMIT  = MAX_RETRIES & {2{RETRY_EN}};
  // The ISSUE cycle counts as the first cycle of the accept window.
  localparam logic [19:0] TIMEOUT_LOAD = {12'd0, ACCEPT_TIMEOUT} - 20'd1;
  localparam logic [19:0] GAP_LOAD     = {4'd0, WRITE_GAP};

  logic [3:0]  state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [7:0]  addr_q, addr_d, value_q, value_d;
  logic        nack_q, nack_d;
  logic [1:0]  retries_q, retries_d;
  logic        retry_q, retry_d;
  logic [7:0]  reg_count_q, reg_count_d;
  logic        com7_reset;

  // A COM7 write with bit 7 set soft-resets the sensor and needs the long settle.
  assign com7_reset = (addr_q == 8'h12) && value_q[7];

  // Next-state and datapath updates for the sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    value_d     = value_q;
    nack_d      = nack_q;
    retries_d   = retries_q;
    retry_d     = retry_q;
    reg_count_d = reg_count_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d     = S_REWIND;
          reg_count_d = 8'd0;
          retries_d   = 2'd0;
          retry_d     = 1'b0;
        end
      end
      S_REWIND: state_d = S_FETCH;
      S_FETCH: begin
        if (init_done) begin
          state_d = S_DONE;
        end else begin
          addr_d  = init_data[15:8];
          value_d = init_data[7:0];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = TIMEOUT_LOAD;
        state_d = S_WACCEPT;
      end
      S_WACCEPT: begin
        if (sccb_busy)            state_d = S_WXFER;
        else if (cnt_q <= 20'd1)  state_d = S_ERROR;
        else                      cnt_d   = cnt_q - 20'd1;
      end
      S_WXFER: begin
        if (!sccb_busy) begin
          nack_d  = sccb_nack;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!nack_q) begin
          if (reg_count_q != 8'hff) reg_count_d = reg_count_q + 8'd1;
          retries_d = 2'd0;
          retry_d   = 1'b0;
          cnt_d     = com7_reset ? RESET_DELAY : GAP_LOAD;
          state_d   = S_GAP;
        end else if (retries_q < RETRY_LIMIT) begin
          retries_d = retries_q + 2'd1;
          retry_d   = 1'b1;
          cnt_d     = GAP_LOAD;
          state_d   = S_GAP;
        end else begin
          state_d = S_ERROR;
        end
      end
      S_GAP: begin
        if (cnt_q <= 20'd1) begin
          state_d = retry_q ? S_ISSUE : S_ADVANCE;
          retry_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 20'd1;
        end
      end
      S_ADVANCE: state_d = S_FETCH;
      default:   state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 20'd0;
      addr_q      <= 8'd0;
      value_q     <= 8'd0;
      nack_q      <= 1'b0;
      retries_q   <= 2'd0;
      retry_q     <= 1'b0;
      reg_count_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      value_q     <= value_d;
      nack_q      <= nack_d;
      retries_q   <= retries_d;
      retry_q     <= retry_d;
      reg_count_q <= reg_count_d;
    end
  end

  // Outputs are pure state decodes, so an async reset clears them at once.
  assign init_reset_n  = (state_q != S_REWIND);
  assign init_continue = (state_q == S_ADVANCE);
  assign sccb_start    = (state_q == S_ISSUE);
  assign cfg_done      = (state_q == S_DONE);
  assign cfg_error     = (state_q == S_ERROR);
  assign busy          = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERROR);
  assign sccb_addr     = addr_q;
  assign sccb_value    = value_q;
  assign reg_count     = reg_count_q;

endmodule

// File: tb/tb_ov7670_config_seq.sv
// Bench for ov7670_config_seq: table-driven init source, randomized SCCB responder,
// and a reference model that derives the expected write stream, gaps and result
// straight from the table and the per-attempt NACK plan.
`timescale 1ns/1ps
module tb_ov7670_config_seq;
  localparam int WG = 100, RD = 50000, AT = 16;
`ifdef OV7670_CFG_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic        clk = 1'b0, reset_n = 1'b1, start = 1'b0;
  logic [15:0] init_data;
  logic        init_done, init_continue, init_reset_n;
  logic [7:0]  sccb_addr, sccb_value, reg_count;
  logic        sccb_start, sccb_busy = 1'b0, sccb_nack = 1'b0;
  logic        busy, cfg_done, cfg_error;
  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  ov7670_config_seq dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .init_data(init_data), .init_done(init_done),
    .init_continue(init_continue), .init_reset_n(init_reset_n),
    .sccb_addr(sccb_addr), .sccb_value(sccb_value), .sccb_start(sccb_start),
    .sccb_busy(sccb_busy), .sccb_nack(sccb_nack),
    .busy(busy), .cfg_done(cfg_done), .cfg_error(cfg_error), .reg_count(reg_count)
  );

  // ov7670_init stand-in: table plus read index
  logic [15:0] tbl [0:15];
  int tbl_n = 0;
  int idx;
  assign init_data = (idx < 16) ? tbl[idx] : 16'h0000;
  assign init_done = (idx >= tbl_n);
  always @(posedge clk or negedge reset_n)
    if (!reset_n)           idx <= 0;
    else if (!init_reset_n) idx <= 0;
    else if (init_continue) idx <= idx + 1;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SCCB responder and pulse monitor (single process, mid-cycle)
  bit never_busy = 1'b0;
  bit nack_plan [0:63];
  int att_base = 0, n_att = 0;
  int phase = 0, acc_cnt = 0, xfer_cnt = 0;
  bit cur_nack = 1'b0;
  logic [15:0] wlog [$];
  int glog [$];
  int gap_from = 0, viol = 0, n_starts = 0, last_start = 0;
  bit gap_pend = 1'b0, prev_p = 1'b0;

  always @(negedge clk) begin
    if (!reset_n) begin
      sccb_busy = 1'b0; sccb_nack = 1'b0; phase = 0; gap_pend = 1'b0; prev_p = 1'b0;
    end else begin
      sccb_nack = 1'b0;
      if ((sccb_start || init_continue) && gap_pend) begin
        glog.push_back(cyc - gap_from);
        gap_pend = 1'b0;
      end
      if (sccb_start && init_continue) viol++;
      if ((sccb_start || init_continue) && prev_p) viol++;
      prev_p = sccb_start || init_continue;
      if (sccb_start) begin
        wlog.push_back({sccb_addr, sccb_value});
        n_starts++;
        last_start = cyc;
        if (!never_busy) begin
          phase    = 1;
          acc_cnt  = $urandom_range(0, 3);
          xfer_cnt = $urandom_range(1, 5);
          cur_nack = nack_plan[(n_att - att_base) & 63];
          n_att++;
        end
      end else begin
        case (phase)
          1: if (acc_cnt == 0) begin sccb_busy = 1'b1; phase = 2; end else acc_cnt--;
          2: if (xfer_cnt == 0) begin
               sccb_busy = 1'b0; sccb_nack = cur_nack;
               gap_from = cyc; gap_pend = 1'b1; phase = 0;
             end else xfer_cnt--;
          default: ;
        endcase
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: every attempt writes the current entry; an ACK advances, a NACK
  // retries (when enabled, up to 3 times) or aborts. The gap is measured from the
  // cycle busy drops to the next start/continue pulse: one check cycle, the idle
  // gap itself, then the pulse.
  logic [15:0] exp_w [$];
  int exp_g [$];
  int exp_cnt;
  bit exp_err;
  task automatic run_model();
    int a, r;
    bit fin;
    a = 0; exp_w.delete(); exp_g.delete(); exp_cnt = 0; exp_err = 1'b0;
    for (int e = 0; e < tbl_n && !exp_err; e++) begin
      r = 0; fin = 1'b0;
      while (!fin) begin
        exp_w.push_back(tbl[e]);
        if (!nack_plan[a]) begin
          exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
          exp_g.push_back(((tbl[e][15:8] == 8'h12) && tbl[e][7]) ? RD + 2 : WG + 2);
          fin = 1'b1;
        end else if (RETRY && r < 3) begin
          r++;
          exp_g.push_back(WG + 2);
        end else begin
          exp_err = 1'b1; fin = 1'b1;
        end
        a++;
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk) reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(negedge clk);
  endtask

  int t_go, t_end;
  task automatic go();
    @(negedge clk) start = 1'b1; t_go = cyc;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_end(input int budget, input bit poke, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (cfg_done || cfg_error) begin ok = 1'b1; t_end = cyc; break; end
      start = poke && busy && ($urandom_range(0, 7) == 0);
    end
    start = 1'b0;
  endtask

  task automatic run_case(input string tag, input int budget, input bit poke);
    int wb, gb, vb;
    bit ok;
    apply_reset();
    wb = wlog.size(); gb = glog.size(); vb = viol; att_base = n_att;
    run_model();
    go();
    wait_end(budget, poke, ok);
    chk({tag, ".finished"}, ok, 1);
    chk({tag, ".done"}, cfg_done, !exp_err);
    chk({tag, ".error"}, cfg_error, exp_err);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".count"}, reg_count, exp_cnt);
    chk({tag, ".nwrites"}, wlog.size() - wb, exp_w.size());
    for (int i = 0; i < exp_w.size() && wb + i < wlog.size(); i++)
      chk({tag, ".write"}, wlog[wb + i], exp_w[i]);
    chk({tag, ".ngaps"}, glog.size() - gb, exp_g.size());
    for (int i = 0; i < exp_g.size() && gb + i < glog.size(); i++)
      chk({tag, ".gap"}, glog[gb + i], exp_g[i]);
    chk({tag, ".pulses"}, viol - vb, 0);
  endtask

  task automatic clear_plan();
    for (int i = 0; i < 64; i++) nack_plan[i] = 1'b0;
  endtask

  initial begin
    bit ok;
    int sb;
    logic [15:0] w;
    clear_plan();
    for (int i = 0; i < 16; i++) tbl[i] = 16'h0000;

    // reset values
    #2 reset_n = 1'b0;
    #1;
    chk("rst.ctl", {busy, cfg_done, cfg_error, sccb_start, init_continue, init_reset_n}, 6'b000001);
    chk("rst.count", reg_count, 0);
    chk("rst.word", {sccb_addr, sccb_value}, 0);

    // three-entry table including a COM7 soft reset
    tbl[0] = 16'h1280; tbl[1] = 16'h1101; tbl[2] = 16'h4010; tbl_n = 3;
    run_case("tbl3", 60000, 1'b0);

    // empty table
    tbl_n = 0;
    run_case("empty", 50, 1'b0);
    chk("empty.latency", t_end - t_go, 3);

    // responder never accepts
    never_busy = 1'b1;
    tbl[0] = 16'h1101; tbl_n = 1;
    apply_reset();
    sb = n_starts;
    go();
    wait_end(200, 1'b0, ok);
    chk("tmo.finished", ok, 1);
    chk("tmo.error", cfg_error, 1);
    chk("tmo.busy", busy, 0);
    chk("tmo.starts", n_starts - sb, 1);
    chk("tmo.latency", t_end - last_start, AT);
    never_busy = 1'b0;

    // NACK on the second write twice, then ACK
    tbl[0] = 16'h1101; tbl[1] = 16'h3a04; tbl[2] = 16'h4010; tbl_n = 3;
    clear_plan(); nack_plan[1] = 1'b1; nack_plan[2] = 1'b1;
    run_case("nack", 5000, 1'b0);
    chk("nack.count_abs", reg_count, RETRY ? 3 : 1);
    clear_plan();

    // reset in the middle of an inter-write gap, then a fresh run
    tbl[0] = 16'h1101; tbl[1] = 16'h1c7f; tbl[2] = 16'h1da2; tbl_n = 3;
    apply_reset();
    go();
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (gap_pend) begin ok = 1'b1; break; end
    end
    chk("midrst.reached", ok, 1);
    repeat (20) @(negedge clk);
    chk("midrst.pre_busy", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst.ctl", {busy, cfg_done, cfg_error, sccb_start, init_continue, init_reset_n}, 6'b000001);
    chk("midrst.count", reg_count, 0);
    chk("midrst.word", {sccb_addr, sccb_value}, 0);
    sb = n_starts;
    repeat (5) @(negedge clk);
    chk("midrst.nostart", n_starts - sb, 0);
    reset_n = 1'b1;
    run_case("rerun", 5000, 1'b0);

    // start pulses while busy must not perturb the sequence
    tbl[0] = 16'h1204; tbl[1] = 16'h1380; tbl[2] = 16'h6b4a; tbl[3] = 16'h0c00; tbl_n = 4;
    run_case("poke", 5000, 1'b1);

    // randomized tables and NACK plans
    for (int it = 0; it < 8; it++) begin
      tbl_n = $urandom_range(0, 6);
      for (int i = 0; i < 16; i++) begin
        w = 16'($urandom);
        if (w[15:8] == 8'h12) w[7] = 1'b0;
        tbl[i] = w;
      end
      if ($urandom_range(0, 1) == 1) tbl[0] = 16'h1204;
      for (int i = 0; i < 64; i++) nack_plan[i] = ($urandom_range(0, 5) == 0);
      run_case("rand", 8000, $urandom_range(0, 1) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
